// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory write bus for prog_loader.
// master: the host link side (drives bytes, observes the memory write bus).
// slave : the loader (accepts bytes, drives the memory write port).
interface prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] pmemaddr;
  logic [31:0] pmemdata;
  logic        pmemwe;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, pmemaddr, pmemdata, pmemwe
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, pmemaddr, pmemdata, pmemwe
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream program loader.
// Frame: START_BYTE, LEN (4 bytes LE, word count), LEN words (4 bytes LE each),
// optionally followed by a 4-byte LE checksum when PROG_LOADER_CHECKSUM_EN is
// defined. Holds the core in reset until a complete, valid image is loaded.
module prog_loader #(
  parameter int          MEM_WORDS  = 256,
  parameter logic [7:0]  START_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,        // synchronous, active-low
  prog_loader_if.slave bus,
  output logic       core_reset,
  output logic       done,
  output logic       error
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WSTB  = 3'd3;  // word assembled, issue the write
  localparam logic [2:0] S_WACK  = 3'd4;  // write cycle, pmemwe high
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd7;
`endif

  logic [2:0]      state;
  logic [1:0]      byte_cnt;
  logic [31:0]     word_sr;
  logic [IDX_W:0]  len_words;
  logic [IDX_W:0]  idx;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]     sum;
`endif

  logic            accept;
  logic            last_byte;
  logic            is_start;
  logic [31:0]     asm_word;
  logic [IDX_W:0]  idx_next;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign is_start  = (bus.rx_data == START_BYTE);
  // Little-endian assembly: each new byte enters at the top, so byte0 ends in [7:0].
  assign asm_word  = {bus.rx_data, word_sr[31:8]};
  assign idx_next  = idx + 1'b1;

  // Frame parser, word writer and all registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: every state element here uses <= so all registers update from the
    // same pre-edge values; mixing in = would make results depend on statement order.
    if (!reset) begin
      state         <= S_IDLE;
      byte_cnt      <= 2'd0;
      word_sr       <= 32'd0;
      len_words     <= '0;
      idx           <= '0;
      bus.pmemaddr  <= 32'd0;
      bus.pmemdata  <= 32'd0;
      bus.pmemwe    <= 1'b0;
      bus.rx_ready  <= 1'b0;
      core_reset    <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum           <= 32'd0;
`endif
    end else begin
      bus.pmemwe   <= 1'b0;
      bus.rx_ready <= 1'b1;

      // NOTE: the default arm keeps an unreachable encoding from stalling the parser.
      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (accept && is_start) begin
            state      <= S_LEN;
            byte_cnt   <= 2'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            core_reset <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum        <= 32'd0;
`endif
          end
        end

        S_LEN: begin
          if (accept) begin
            word_sr  <= asm_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              if (asm_word > 32'(MEM_WORDS)) begin
                state <= S_ERROR;
                error <= 1'b1;
              end else if (asm_word == 32'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state <= S_CSUM;
`else
                state      <= S_DONE;
                done       <= 1'b1;
                core_reset <= 1'b0;
`endif
              end else begin
                state     <= S_DATA;
                len_words <= asm_word[IDX_W:0];
                idx       <= '0;
              end
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            word_sr  <= asm_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              // Close the byte gate now so nothing arrives while the write is pending.
              state        <= S_WSTB;
              bus.rx_ready <= 1'b0;
            end
          end
        end

        S_WSTB: begin
          bus.pmemwe   <= 1'b1;
          bus.pmemaddr <= 32'(idx) << 2;
          bus.pmemdata <= word_sr;
          bus.rx_ready <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum          <= sum + word_sr;
`endif
          state        <= S_WACK;
        end

        S_WACK: begin
          if (idx_next == len_words) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state <= S_CSUM;
`else
            state      <= S_DONE;
            done       <= 1'b1;
            core_reset <= 1'b0;
`endif
          end else begin
            idx   <= idx_next;
            state <= S_DATA;
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            word_sr  <= asm_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              if (asm_word == sum) begin
                state      <= S_DONE;
                done       <= 1'b1;
                core_reset <= 1'b0;
              end else begin
                state <= S_ERROR;
                error <= 1'b1;
              end
            end
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
